// File: rtl/apb3_mux_pkg.sv
// rtl/apb3_mux_pkg.sv - shared state/cause types and width helpers for the APB3 slot mux
package apb3_mux_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } mux_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_DECODE  = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_SLAVE   = 2'b11
  } err_cause_e;

  localparam int DATA_W = 32;

  function automatic int slot_idx_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

  function automatic int wait_cnt_w(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/apb3_wait_timer.sv
// rtl/apb3_wait_timer.sv - access-phase wait counter with expiry compare
module apb3_wait_timer
  import apb3_mux_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = wait_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  // Holds at the limit so an expiry stays asserted until the transfer is retired.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_wdog_off
      assign expired = 1'b0;
    end else begin : g_wdog_on
      assign expired = (cnt_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb3_slot_mux.sv
// rtl/apb3_slot_mux.sv - APB3 one-to-NUM_SLOTS decoder/mux with slot enables and wait watchdog
// Optional error capture log enabled by APB_ERR_LOG_EN.
module apb3_slot_mux
  import apb3_mux_pkg::*;
#(
  parameter int NUM_SLOTS      = 8,
  parameter int ADDR_W         = 32,
  parameter int SLOT_LSB       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        PCLK,
  input  logic                        PRESETN,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [NUM_SLOTS-1:0]        PSELS,
  output logic [SLOT_LSB-1:0]         PADDRS,
  output logic                        PENABLES,
  output logic                        PWRITES,
  output logic [DATA_W-1:0]           PWDATAS,
  input  logic [NUM_SLOTS*DATA_W-1:0] PRDATAS,
  input  logic [NUM_SLOTS-1:0]        PREADYS,
  input  logic [NUM_SLOTS-1:0]        PSLVERRS,
  input  logic [NUM_SLOTS-1:0]        SLOT_EN,
  input  logic [NUM_SLOTS-1:0]        TIMEOUT_CLR,
  output logic [NUM_SLOTS-1:0]        TIMEOUT_STS,
  output logic                        TIMEOUT_IRQ
`ifdef APB_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]           ERR_ADDR,
  output logic [1:0]                  ERR_CAUSE,
  output logic                        ERR_VALID,
  input  logic                        ERR_CLR
`endif
);

  localparam int SW = slot_idx_w(NUM_SLOTS);
  localparam int NP = 2 ** SW;

  mux_state_e          state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d, sel_slot;
  logic                hit_q, hit_d, sel_on;
  logic [NP-1:0]       en_pad, rdy_pad, err_pad;
  logic [DATA_W-1:0]   rdata_arr [NP];
  logic                in_access, setup, slave_rdy, expired, timeout_hit, wait_en;
  logic [NUM_SLOTS-1:0] sts_set;

  assign PADDRS   = PADDR[SLOT_LSB-1:0];
  assign PWDATAS  = PWDATA;
  assign PWRITES  = PWRITE;
  assign PENABLES = PENABLE;

  // Per-slot vectors are padded to the full index range so out-of-range slots read as absent.
  assign slot_d  = PADDR[SLOT_LSB +: SW];
  assign en_pad  = NP'(SLOT_EN);
  assign rdy_pad = NP'(PREADYS);
  assign err_pad = NP'(PSLVERRS);
  assign hit_d   = en_pad[slot_d];

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      rdata_arr[k] = '0;
    end
    for (int k = 0; k < NUM_SLOTS; k++) begin
      rdata_arr[k] = PRDATAS[k*DATA_W +: DATA_W];
    end
  end

  assign in_access   = (state_q == ST_ACCESS);
  assign setup       = (state_q == ST_IDLE) && PSEL && !PENABLE;
  assign slave_rdy   = rdy_pad[slot_q];
  assign wait_en     = in_access && PSEL && hit_q && !slave_rdy;
  assign timeout_hit = wait_en && expired;

  apb3_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (PCLK),
    .resetn  (PRESETN),
    .clr     (!in_access),
    .en      (wait_en),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    sel_on   = 1'b0;
    sel_slot = slot_q;
    PREADY   = 1'b0;
    PSLVERR  = 1'b0;
    PRDATA   = '0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          sel_on   = hit_d;
          sel_slot = slot_d;
          state_d  = ST_ACCESS;
        end else if (PSEL && PENABLE) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!hit_q) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
        end else begin
          sel_on = PSEL;
          if (timeout_hit) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
          end else begin
            PREADY  = slave_rdy;
            PSLVERR = err_pad[slot_q] & slave_rdy;
            PRDATA  = rdata_arr[slot_q];
          end
        end
        if (!PSEL || PREADY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    PSELS   = '0;
    sts_set = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      PSELS[k]   = sel_on && (sel_slot == SW'(k));
      sts_set[k] = timeout_hit && (slot_q == SW'(k));
    end
  end

  // A timeout set on the same edge as a clear of that bit keeps the flag.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      hit_q       <= 1'b0;
      TIMEOUT_STS <= '0;
    end else begin
      state_q     <= state_d;
      if (setup) begin
        slot_q <= slot_d;
        hit_q  <= hit_d;
      end
      TIMEOUT_STS <= (TIMEOUT_STS & ~TIMEOUT_CLR) | sts_set;
    end
  end

  assign TIMEOUT_IRQ = |TIMEOUT_STS;

`ifdef APB_ERR_LOG_EN
  logic       decode_err, slave_err, err_evt;
  err_cause_e err_code;
  logic       err_valid_q;
  logic [ADDR_W-1:0] err_addr_q;
  err_cause_e err_cause_q;

  assign decode_err = PSEL && (((state_q == ST_IDLE) && PENABLE) || (in_access && !hit_q));
  assign slave_err  = in_access && PSEL && hit_q && slave_rdy && err_pad[slot_q];

  always_comb begin
    err_evt  = 1'b1;
    err_code = ERR_NONE;
    if (timeout_hit) begin
      err_code = ERR_TIMEOUT;
    end else if (slave_err) begin
      err_code = ERR_SLAVE;
    end else if (decode_err) begin
      err_code = ERR_DECODE;
    end else begin
      err_evt = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= ERR_NONE;
    end else if (err_evt && (!err_valid_q || ERR_CLR)) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= PADDR;
      err_cause_q <= err_code;
    end else if (ERR_CLR) begin
      err_valid_q <= 1'b0;
    end
  end

  assign ERR_VALID = err_valid_q;
  assign ERR_ADDR  = err_addr_q;
  assign ERR_CAUSE = err_cause_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^PADDR[ADDR_W-1:SLOT_LSB+SW];
`endif

endmodule

// File: tb/tb_apb3_slot_mux.sv
// tb/tb_apb3_slot_mux.sv - directed transfers checked cycle by cycle against a transaction-level model
module tb_apb3_slot_mux;

  localparam int NS = 8;
  localparam int TO = 4;

  logic              PCLK = 1'b0;
  logic              PRESETN;
  logic [31:0]       PADDR;
  logic              PSEL, PENABLE, PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [NS-1:0]     PSELS;
  logic [7:0]        PADDRS;
  logic              PENABLES, PWRITES;
  logic [31:0]       PWDATAS;
  logic [NS*32-1:0]  PRDATAS;
  logic [NS-1:0]     PREADYS, PSLVERRS, SLOT_EN, TIMEOUT_CLR, TIMEOUT_STS;
  logic              TIMEOUT_IRQ;
`ifdef APB_ERR_LOG_EN
  logic [31:0]       ERR_ADDR;
  logic [1:0]        ERR_CAUSE;
  logic              ERR_VALID;
  logic              ERR_CLR = 1'b0;
`endif

  always #5 PCLK = ~PCLK;

  apb3_slot_mux #(
    .NUM_SLOTS(NS), .ADDR_W(32), .SLOT_LSB(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PSELS(PSELS), .PADDRS(PADDRS), .PENABLES(PENABLES), .PWRITES(PWRITES), .PWDATAS(PWDATAS),
    .PRDATAS(PRDATAS), .PREADYS(PREADYS), .PSLVERRS(PSLVERRS), .SLOT_EN(SLOT_EN),
    .TIMEOUT_CLR(TIMEOUT_CLR), .TIMEOUT_STS(TIMEOUT_STS), .TIMEOUT_IRQ(TIMEOUT_IRQ)
`ifdef APB_ERR_LOG_EN
    , .ERR_ADDR(ERR_ADDR), .ERR_CAUSE(ERR_CAUSE), .ERR_VALID(ERR_VALID), .ERR_CLR(ERR_CLR)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit            exp_valid;
  logic [NS-1:0] exp_psels, exp_sts, pend_set;
  logic          exp_pready, exp_pslverr, exp_pwrite, exp_penable;
  logic [31:0]   exp_prdata, exp_pwdata;
  logic [7:0]    exp_paddrs;

  function automatic void chk(string what, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", what, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] slot_data(input int k);
    return (k == 2) ? 32'hA5A5_0001 : 32'hC0DE_0000 + 32'(k * 'h111);
  endfunction

  function automatic void set_exp(input logic [NS-1:0] ps, input logic r, input logic e,
                                  input logic [31:0] d);
    exp_psels   = ps;
    exp_pready  = r;
    exp_pslverr = e;
    exp_prdata  = d;
  endfunction

  always @(negedge PCLK) begin
    if (exp_valid) begin
      chk("psels",    32'(PSELS),       32'(exp_psels));
      chk("pready",   32'(PREADY),      32'(exp_pready));
      chk("pslverr",  32'(PSLVERR),     32'(exp_pslverr));
      chk("prdata",   PRDATA,           exp_prdata);
      chk("paddrs",   32'(PADDRS),      32'(exp_paddrs));
      chk("pwrites",  32'(PWRITES),     32'(exp_pwrite));
      chk("penables", 32'(PENABLES),    32'(exp_penable));
      chk("pwdatas",  PWDATAS,          exp_pwdata);
      chk("sts",      32'(TIMEOUT_STS), 32'(exp_sts));
      chk("irq",      32'(TIMEOUT_IRQ), 32'(|exp_sts));
    end
  end

  // Advance one clock; the status model applies the previous cycle's set/clear/reset.
  task automatic tick();
    logic [NS-1:0] clr_now = TIMEOUT_CLR;
    logic [NS-1:0] set_now = pend_set;
    bit            rst_now = !PRESETN;
    @(posedge PCLK);
    #1;
    exp_sts     = rst_now ? '0 : ((exp_sts & ~clr_now) | set_now);
    pend_set    = '0;
    TIMEOUT_CLR = '0;
  endtask

  task automatic settle();
    @(negedge PCLK);
    #1;
  endtask

  task automatic idle(input int n, input logic [NS-1:0] clr);
    for (int i = 0; i < n; i++) begin
      tick();
      PSEL = 1'b0; PENABLE = 1'b0; PREADYS = '0; PSLVERRS = '0;
      TIMEOUT_CLR = (i == 0) ? clr : '0;
      exp_penable = 1'b0;
      set_exp('0, 1'b0, 1'b0, '0);
    end
  endtask

  // One complete transfer: a selected slave answers after wait_n wait states,
  // every other slave answers ready-with-error so a wrong mux select shows up.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int wait_n, input logic serr, input logic [NS-1:0] clr_during,
                      output int acc_n);
    int            s;
    bit            hit, done;
    logic [NS-1:0] sbit;
    s    = int'(addr[10:8]);
    hit  = SLOT_EN[s];
    sbit = 8'(1) << s;
    tick();
    PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
    PREADYS = ~sbit; PSLVERRS = ~sbit;
    exp_paddrs = addr[7:0]; exp_pwrite = wr; exp_pwdata = wd; exp_penable = 1'b0;
    set_exp(hit ? sbit : '0, 1'b0, 1'b0, '0);
    exp_valid = 1'b1;
    done  = 1'b0;
    acc_n = 0;
    while (!done && acc_n < 40) begin
      tick();
      acc_n++;
      PENABLE = 1'b1; exp_penable = 1'b1;
      TIMEOUT_CLR = clr_during;
      PREADYS  = ~sbit | ((acc_n > wait_n) ? sbit : '0);
      PSLVERRS = ~sbit | (serr ? sbit : '0);
      if (!hit) begin
        set_exp('0, 1'b1, 1'b1, '0);
        done = 1'b1;
      end else if (acc_n > wait_n) begin
        set_exp(sbit, 1'b1, serr, slot_data(s));
        done = 1'b1;
      end else if (acc_n == TO + 1) begin
        set_exp(sbit, 1'b1, 1'b1, '0);
        pend_set = sbit;
        done = 1'b1;
      end else begin
        set_exp(sbit, 1'b0, 1'b0, slot_data(s));
      end
    end
  endtask

  int acc;

  initial begin
    PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PREADYS = '0; PSLVERRS = '0;
    SLOT_EN = '1; TIMEOUT_CLR = '0;
    for (int k = 0; k < NS; k++) PRDATAS[k*32 +: 32] = slot_data(k);
    exp_valid = 1'b0; exp_sts = '0; pend_set = '0;
    exp_paddrs = '0; exp_pwrite = 1'b0; exp_pwdata = '0; exp_penable = 1'b0;
    set_exp('0, 1'b0, 1'b0, '0);

    tick(); tick();
    exp_valid = 1'b1;
    settle();
    chk("rst_psels",  32'(PSELS),       32'h0);
    chk("rst_pready", 32'(PREADY),      32'h0);
    chk("rst_sts",    32'(TIMEOUT_STS), 32'h0);
    chk("rst_irq",    32'(TIMEOUT_IRQ), 32'h0);
    PRESETN = 1'b1;

    xfer(32'h0000_0204, 1'b0, 32'h0, 0, 1'b0, '0, acc);
    settle();
    chk("rd2_prdata",  PRDATA,       32'hA5A5_0001);
    chk("rd2_psels",   32'(PSELS),   32'h04);
    chk("rd2_pslverr", 32'(PSLVERR), 32'h0);
    chk("rd2_paddrs",  32'(PADDRS),  32'h04);
    chk("rd2_len",     32'(acc),     32'd1);
    idle(1, '0);

    SLOT_EN = 8'hF7;
    xfer(32'h0000_0300, 1'b1, 32'h1234_5678, 0, 1'b0, '0, acc);
    settle();
    chk("dis3_pslverr", 32'(PSLVERR), 32'h1);
    chk("dis3_psels",   32'(PSELS),   32'h0);
    chk("dis3_len",     32'(acc),     32'd1);
    SLOT_EN = '1;
    idle(1, '0);

    tick();
    PADDR = 32'h0000_0104; PSEL = 1'b1; PENABLE = 1'b1; PREADYS = '1; PSLVERRS = '0;
    exp_paddrs = 8'h04; exp_penable = 1'b1;
    set_exp('0, 1'b1, 1'b1, '0);
    settle();
    chk("proto_pready",  32'(PREADY),  32'h1);
    chk("proto_pslverr", 32'(PSLVERR), 32'h1);
    idle(1, '0);

    xfer(32'h0000_0110, 1'b0, 32'h0, 99, 1'b0, '0, acc);
    settle();
    chk("to1_len",     32'(acc),     32'd5);
    chk("to1_pslverr", 32'(PSLVERR), 32'h1);
    idle(1, '0);
    settle();
    chk("to1_sts", 32'(TIMEOUT_STS), 32'h02);
    chk("to1_irq", 32'(TIMEOUT_IRQ), 32'h1);
    idle(1, 8'h02);
    idle(1, '0);
    settle();
    chk("to1_clr", 32'(TIMEOUT_STS), 32'h0);

    xfer(32'h0000_0508, 1'b1, 32'hDEAD_BEEF, 3, 1'b1, '0, acc);
    settle();
    chk("ws5_len",     32'(acc),     32'd4);
    chk("ws5_pslverr", 32'(PSLVERR), 32'h1);
    idle(1, '0);
    settle();
    chk("ws5_sts", 32'(TIMEOUT_STS), 32'h0);

    xfer(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0, '0, acc);
    settle();
    chk("b2b0_psels", 32'(PSELS), 32'h01);
    xfer(32'h0000_07FC, 1'b1, 32'h0BAD_F00D, 1, 1'b0, '0, acc);
    settle();
    chk("b2b7_psels", 32'(PSELS), 32'h80);
    chk("b2b7_len",   32'(acc),   32'd2);

    xfer(32'h0000_0400, 1'b0, 32'h0, 99, 1'b0, 8'h10, acc);
    idle(1, '0);
    settle();
    chk("to4_setwins", 32'(TIMEOUT_STS), 32'h10);

    tick();
    PADDR = 32'h0000_0600; PSEL = 1'b1; PENABLE = 1'b0; PREADYS = 8'hBF; PSLVERRS = 8'hBF;
    exp_paddrs = 8'h00; exp_penable = 1'b0;
    set_exp(8'h40, 1'b0, 1'b0, '0);
    tick();
    PENABLE = 1'b1; exp_penable = 1'b1;
    set_exp(8'h40, 1'b0, 1'b0, slot_data(6));
    tick();
    PRESETN = 1'b0;
    set_exp(8'h40, 1'b0, 1'b0, slot_data(6));
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; exp_penable = 1'b0;
    set_exp('0, 1'b0, 1'b0, '0);
    settle();
    chk("mrst_psels",  32'(PSELS),       32'h0);
    chk("mrst_pready", 32'(PREADY),      32'h0);
    chk("mrst_sts",    32'(TIMEOUT_STS), 32'h0);
    PRESETN = 1'b1;

    xfer(32'h0000_0204, 1'b0, 32'h0, 0, 1'b0, '0, acc);
    settle();
    chk("post_prdata", PRDATA, 32'hA5A5_0001);
    idle(2, '0);
    exp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
